// File: rtl/alu_arbiter.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : alu_arbiter (with embedded combinational alu)              |
// | Description : Shares one combinational ALU between two requesters        |
// |               (0: fetch/PC-increment, 1: execute). One operation at a    |
// |               time: IDLE accepts, EXEC captures the ALU output, RESP     |
// |               returns it to the granted requester.                       |
// | Ports       : clk, rst_n (async active-low)                              |
// |               reqN_valid/ready/op/a/b  - request channels (N = 0, 1)     |
// |               rspN_valid/ready         - response channels               |
// |               rsp_data                 - shared registered result        |
// |               busy                     - high outside IDLE               |
// | Config      : ALU_ARB_FIXED_PRIO_EN defined -> requester 0 always wins   |
// |               a tie; undefined (default) -> round-robin.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

`ifndef RegWidth
`define RegWidth 16
`endif
`ifndef AluOpWidth
`define AluOpWidth 3
`endif

// +--------------------------------------------------------------------------+
// | Module      : alu                                                        |
// | Description : Purely combinational ALU, wrap-around arithmetic.          |
// |               0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not reg1,              |
// |               6 reg1 << 1, 7 reg1 >> 1. Requires OP_W >= 3.              |
// | Ports       : op, reg1, reg2 in; result out                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu #(
    parameter int DATA_W = `RegWidth,
    parameter int OP_W   = `AluOpWidth
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] result
);
    localparam logic [OP_W-1:0] c_OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_OR  = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_NOT = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_SHL = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_SHR = OP_W'(7);

    always_comb begin
        result = '0;
        case (op)
            c_OP_ADD: result = reg1 + reg2;
            c_OP_SUB: result = reg1 - reg2;
            c_OP_AND: result = reg1 & reg2;
            c_OP_OR:  result = reg1 | reg2;
            c_OP_XOR: result = reg1 ^ reg2;
            c_OP_NOT: result = ~reg1;
            c_OP_SHL: result = reg1 << 1;
            c_OP_SHR: result = reg1 >> 1;
            default:  result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int DATA_W = `RegWidth,
    parameter int OP_W   = `AluOpWidth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]        r_state;
    logic              r_gnt;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_win;        // requester index that wins in IDLE
    logic              w_accept;
    logic              w_rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is valid; 1 only gets through alone.
    assign w_win = ~req0_valid;
`else
    logic r_last_grant;

    // On a tie, favour the requester that was not served last.
    always_comb begin
        w_win = req1_valid;
        if (req0_valid && req1_valid) begin
            w_win = ~r_last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (r_state == c_ST_RESP && w_rsp_ready) begin
            r_last_grant <= r_gnt;
        end
    end
`endif

    assign w_accept = (r_state == c_ST_IDLE) && (req0_valid || req1_valid);

    // Ready is gated by rst_n so nothing looks accepted while held in reset.
    assign req0_ready  = rst_n && w_accept && !w_win;
    assign req1_ready  = rst_n && w_accept &&  w_win;
    assign rsp0_valid  = (r_state == c_ST_RESP) && !r_gnt;
    assign rsp1_valid  = (r_state == c_ST_RESP) &&  r_gnt;
    assign w_rsp_ready = r_gnt ? rsp1_ready : rsp0_ready;
    assign busy        = (r_state != c_ST_IDLE);
    assign rsp_data    = r_rsp_data;

    // The ALU only ever sees latched operands, so requesters may change
    // their ports freely once their request has been accepted.
    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .op     (r_op),
        .reg1   (r_a),
        .reg2   (r_b),
        .result (w_alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_gnt      <= 1'b0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= w_win;
                        r_op    <= w_win ? req1_op : req0_op;
                        r_a     <= w_win ? req1_a  : req0_a;
                        r_b     <= w_win ? req1_b  : req0_b;
                        r_state <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_rsp_data <= w_alu_result;
                    r_state    <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (w_rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module      : tb_alu_arbiter                                             |
// | Description : Self-checking bench for alu_arbiter. Accepted requests     |
// |               push a model result onto a scoreboard; completed responses |
// |               pop and compare data and response channel. Directed        |
// |               checks cover reset, latency, operand isolation, ties,      |
// |               backpressure and reset during an operation.                |
// | Config      : honours ALU_ARB_FIXED_PRIO_EN for expected tie order.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;
    localparam int W    = 16;
    localparam int OP_W = 3;

    localparam logic [2:0] c_ADD = 3'd0;
    localparam logic [2:0] c_SUB = 3'd1;
    localparam logic [2:0] c_AND = 3'd2;
    localparam logic [2:0] c_XOR = 3'd4;
    localparam logic [2:0] c_NOT = 3'd5;
    localparam logic [2:0] c_SHL = 3'd6;
    localparam logic [2:0] c_SHR = 3'd7;

    logic            clk;
    logic            rst_n;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OP_W-1:0] req0_op, req1_op;
    logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0]    rsp_data;
    logic            busy;

    typedef struct packed {
        logic         ch;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   ord_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_arbiter #(
        .DATA_W (W),
        .OP_W   (OP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~a;
            3'd6:    r = {a[W-2:0], 1'b0};
            default: r = {1'b0, a[W-1:1]};
        endcase
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (req0_valid && req0_ready)
                sb_q.push_back({1'b0, model(req0_op, req0_a, req0_b)});
            if (req1_valid && req1_ready)
                sb_q.push_back({1'b1, model(req1_op, req1_a, req1_b)});
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                ord_q.push_back(rsp1_valid ? 1 : 0);
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_chan", {31'd0, rsp1_valid}, {31'd0, e.ch});
                    chk("sb_data", {16'd0, rsp_data}, {16'd0, e.data});
                    chk("sb_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
                end
            end
        end
    end

    task automatic send(input int which, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        int k;
        if (which == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        k = 0;
        @(negedge clk);
        while (!((which == 0) ? req0_ready : req1_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", {31'd0, (which == 0) ? req0_ready : req1_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (which == 0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk("drain_empty", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_ord;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = c_ADD; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_op = c_ADD; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state, with valids high to confirm ready stays low.
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;

        // Single add with latency and operand isolation.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = c_ADD; req0_a = 16'd2; req0_b = 16'd3; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("acc_req0_ready", req0_ready, 1);
        chk("acc_req1_ready", req1_ready, 0);
        chk("acc_busy", busy, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 16'd100;
        @(negedge clk);
        chk("exec_busy", busy, 1);
        chk("exec_rsp0_valid", rsp0_valid, 0);
        chk("exec_req0_ready", req0_ready, 0);
        @(negedge clk);
        chk("resp_rsp0_valid", rsp0_valid, 1);
        chk("resp_rsp_data", rsp_data, 5);
        chk("resp_rsp1_valid", rsp1_valid, 0);
        @(negedge clk);
        chk("after_busy", busy, 0);
        drain();

        // Wrap-around and a spread of opcodes on both requesters.
        rsp1_ready = 1'b1;
        send(1, c_ADD, 16'hFFFF, 16'h0001); drain();
        send(0, c_SUB, 16'h0003, 16'h0005); drain();
        send(1, c_AND, 16'hF0F0, 16'hFF00); drain();
        send(0, c_XOR, 16'hAAAA, 16'h5555); drain();
        send(1, c_NOT, 16'h1234, 16'h0000); drain();
        send(0, c_SHL, 16'h8001, 16'h0000); drain();
        send(1, c_SHR, 16'h8001, 16'h0000); drain();

        // Reset while in EXEC: in-flight op is dropped.
        send(0, c_ADD, 16'd2, 16'd3);
        #2; rst_n = 1'b0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp0_valid", rsp0_valid, 0);
        chk("mid_rst_rsp1_valid", rsp1_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
        end

        // Continuous tie: order must start with 0.
        ord_q.delete();
        req0_valid = 1'b1; req0_op = c_ADD; req0_a = 16'd2; req0_b = 16'd3;
        req1_valid = 1'b1; req1_op = c_ADD; req1_a = 16'd7; req1_b = 16'd1;
        k = 0;
        while (ord_q.size() < 4 && k < 40) begin
            @(posedge clk);
            k++;
        end
        #1; req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_count", ord_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_ord = 0;
`else
            exp_ord = i % 2;
`endif
            if (ord_q.size() > i) chk($sformatf("tie_order%0d", i), ord_q[i], exp_ord);
        end
        drain();

        // Backpressure on requester 0 while requester 1 waits.
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = c_ADD; req1_a = 16'd7; req1_b = 16'd1;
        send(0, c_ADD, 16'd2, 16'd3);
        @(negedge clk);
        chk("bp_exec_req1_ready", req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp_data", rsp_data, 5);
            chk("bp_busy", busy, 1);
            chk("bp_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_consume_req1_ready", req1_ready, 0);
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_req1_ready", req1_ready, 1);
        rsp1_ready = 1'b1;
        @(posedge clk); #1; req1_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
